// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan encoder: FSM state encoding and default parameters.
// The optional auto-repeat feature is selected by the KEY_REPEAT_EN macro in the top module.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_t;

    localparam int DEF_N_KEYS          = 10;
    localparam int DEF_CODE_W          = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 7;
    localparam int DEF_DIV_RATIO       = 100;
    localparam int DEF_REPEAT_CYCLES   = 50;

endpackage

// File: rtl/freq_divider_n.sv
// Free-running divide-by-DIV_RATIO counter producing a registered 50% duty tick.
// The tick is high for the first half of each count period.
module freq_divider_n
    import keypad_pkg::*;
#(
    parameter int DIV_RATIO = DEF_DIV_RATIO
) (
    input  logic Hz_100_clock,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV_RATIO - 1);
    localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(DIV_RATIO / 2);

    if ((DIV_RATIO < 2) || ((DIV_RATIO % 2) != 0)) begin : g_bad_div_ratio
        $error("freq_divider_n: DIV_RATIO must be even and >= 2");
    end

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_next_s;
    logic             tick_r;

    // Next count value with wrap at the end of the period
    always_comb begin
        cnt_next_s = cnt_r + DIV_W'(1);
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = {DIV_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + DIV_W'(1);
        end
    end

    // Count register and registered tick decode of the upcoming count
    always_ff @(posedge Hz_100_clock) begin
        if (clear) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s < CNT_HALF);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/keypad_scan_encoder.sv
// Priority keypad encoder with press/release debounce, one-shot load strobe and slow tick mux.
// Define KEY_REPEAT_EN to add periodic auto-repeat strobes while a key stays held.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int CODE_W          = DEF_CODE_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DIV_RATIO       = DEF_DIV_RATIO,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              Hz_100_clock,
    input  logic              clear,
    input  logic [N_KEYS-1:0] teclado,
    input  logic              enablen,
    output logic [CODE_W-1:0] D,
    output logic              loadn,
    output logic              key_strobe,
    output logic              key_held,
    output logic              pgt_1Hz
);

    // Counter holds samples seen minus one; the last sample of a run lands on DB_LAST.
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);

    if (CODE_W < $clog2(N_KEYS)) begin : g_bad_code_w
        $error("keypad_scan_encoder: CODE_W too small for N_KEYS");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("keypad_scan_encoder: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("keypad_scan_encoder: REPEAT_CYCLES must be >= 1");
    end

    key_state_t        state_r;
    logic [CODE_W-1:0] code_r;
    logic [DB_W-1:0]   cnt_r;
    logic [CODE_W-1:0] d_r;
    logic              strobe_r;
    logic              loadn_r;
    logic              held_r;
    logic              cand_valid_s;
    logic [CODE_W-1:0] cand_code_s;
    logic              tick_s;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_r;
`endif

    // Highest asserted key index wins
    always_comb begin
        cand_valid_s = |teclado;
        cand_code_s  = {CODE_W{1'b0}};
        for (int i = 0; i < N_KEYS; i++) begin
            cand_code_s = teclado[i] ? CODE_W'(i) : cand_code_s;
        end
    end

    // Scan FSM with registered code, strobe and held outputs
    always_ff @(posedge Hz_100_clock) begin
        if (clear) begin
            state_r  <= ST_IDLE;
            code_r   <= {CODE_W{1'b0}};
            cnt_r    <= {DB_W{1'b0}};
            d_r      <= {CODE_W{1'b0}};
            strobe_r <= 1'b0;
            loadn_r  <= 1'b1;
            held_r   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_r    <= {REP_W{1'b0}};
`endif
        end else begin
            strobe_r <= 1'b0;
            loadn_r  <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (cand_valid_s && !enablen) begin
                        code_r <= cand_code_s;
                        cnt_r  <= {DB_W{1'b0}};
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_r  <= ST_HELD;
                            d_r      <= cand_code_s;
                            strobe_r <= 1'b1;
                            loadn_r  <= 1'b0;
                            held_r   <= 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_r    <= {REP_W{1'b0}};
`endif
                        end else begin
                            state_r <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (enablen || !cand_valid_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {DB_W{1'b0}};
                    end else if (cand_code_s != code_r) begin
                        code_r <= cand_code_s;
                        cnt_r  <= {DB_W{1'b0}};
                    end else if (cnt_r == DB_LAST) begin
                        state_r  <= ST_HELD;
                        d_r      <= code_r;
                        strobe_r <= 1'b1;
                        loadn_r  <= 1'b0;
                        held_r   <= 1'b1;
                        cnt_r    <= {DB_W{1'b0}};
`ifdef KEY_REPEAT_EN
                        rep_r    <= {REP_W{1'b0}};
`endif
                    end else begin
                        cnt_r <= cnt_r + DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!cand_valid_s) begin
                        cnt_r <= {DB_W{1'b0}};
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_r <= ST_IDLE;
                            held_r  <= 1'b0;
                        end else begin
                            state_r <= ST_RELEASE;
                        end
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (rep_r == REP_LAST) begin
                            rep_r    <= {REP_W{1'b0}};
                            strobe_r <= 1'b1;
                            loadn_r  <= 1'b0;
                        end else begin
                            rep_r <= rep_r + REP_W'(1);
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    // A returning key resumes the hold silently; only a full release re-arms
                    if (cand_valid_s) begin
                        state_r <= ST_HELD;
                        cnt_r   <= {DB_W{1'b0}};
`ifdef KEY_REPEAT_EN
                        rep_r   <= {REP_W{1'b0}};
`endif
                    end else if (cnt_r == DB_LAST) begin
                        state_r <= ST_IDLE;
                        held_r  <= 1'b0;
                        cnt_r   <= {DB_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + DB_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {DB_W{1'b0}};
                    held_r  <= 1'b0;
                end
            endcase
        end
    end

    freq_divider_n #(
        .DIV_RATIO (DIV_RATIO)
    ) u_div (
        .Hz_100_clock (Hz_100_clock),
        .clear        (clear),
        .tick         (tick_s)
    );

    assign D          = d_r;
    assign loadn      = loadn_r;
    assign key_strobe = strobe_r;
    assign key_held   = held_r;
    assign pgt_1Hz    = enablen ? tick_s : strobe_r;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed self-checking bench for keypad_scan_encoder at default parameters.
// Define KEY_REPEAT_EN for both bench and RTL to include the auto-repeat scenario.
module tb_keypad_scan_encoder;

    logic       clk = 1'b0;
    logic       clear;
    logic [9:0] teclado;
    logic       enablen;
    logic [3:0] d;
    logic       loadn;
    logic       key_strobe;
    logic       key_held;
    logic       pgt;

    int checks   = 0;
    int failures = 0;

    keypad_scan_encoder #(
        .N_KEYS          (10),
        .CODE_W          (4),
        .DEBOUNCE_CYCLES (7),
        .DIV_RATIO       (100),
        .REPEAT_CYCLES   (50)
    ) dut (
        .Hz_100_clock (clk),
        .clear        (clear),
        .teclado      (teclado),
        .enablen      (enablen),
        .D            (d),
        .loadn        (loadn),
        .key_strobe   (key_strobe),
        .key_held     (key_held),
        .pgt_1Hz      (pgt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Advance n cycles, tallying strobe cycles, loadn-low cycles and pgt/key_strobe disagreement
    task automatic run(input int n, output int strobes, output int lows, output int pgt_bad);
        strobes = 0;
        lows    = 0;
        pgt_bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (key_strobe === 1'b1) strobes++;
            if (loadn === 1'b0) lows++;
            if (!enablen && (pgt !== key_strobe)) pgt_bad++;
        end
    endtask

    task automatic test_reset();
        int s, l, pb;
        clear   = 1'b1;
        enablen = 1'b1;
        teclado = 10'h008;
        step();
        step();
        checks++; if (d !== 4'd0) begin failures++; $display("FAIL reset_d: got %0d expected 0", d); end
        checks++; if (loadn !== 1'b1) begin failures++; $display("FAIL reset_loadn: got %b expected 1", loadn); end
        checks++; if (key_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b expected 0", key_strobe); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b expected 0", key_held); end
        checks++; if (pgt !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b expected 0", pgt); end
        clear   = 1'b0;
        enablen = 1'b0;
        teclado = 10'h000;
        run(3, s, l, pb);
    endtask

    task automatic test_single_press();
        int s, l, pb, s2, l2, pb2;
        teclado = 10'h008;
        run(6, s, l, pb);
        checks++; if (s !== 0) begin failures++; $display("FAIL press_6_cycles: got %0d strobes expected 0", s); end
        teclado = 10'h000;
        run(10, s, l, pb);
        teclado = 10'h008;
        run(7, s, l, pb);
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held: got %b expected 1", key_held); end
        teclado = 10'h000;
        run(10, s2, l2, pb2);
        checks++; if (s + s2 !== 1) begin failures++; $display("FAIL press_strobes: got %0d expected 1", s + s2); end
        checks++; if (l + l2 !== 1) begin failures++; $display("FAIL press_loadn_lows: got %0d expected 1", l + l2); end
        checks++; if (d !== 4'd3) begin failures++; $display("FAIL press_d: got %0d expected 3", d); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL press_released: got %b expected 0", key_held); end
        checks++; if (pb + pb2 !== 0) begin failures++; $display("FAIL pgt_follows_strobe: got %0d bad cycles expected 0", pb + pb2); end
    endtask

    task automatic test_priority_glitch();
        int s, l, pb;
        teclado = 10'h204;
        run(10, s, l, pb);
        checks++; if (s !== 1) begin failures++; $display("FAIL prio_strobes: got %0d expected 1", s); end
        checks++; if (d !== 4'd9) begin failures++; $display("FAIL prio_d: got %0d expected 9", d); end
        teclado = 10'h000;
        run(10, s, l, pb);
        teclado = 10'h020;
        run(5, s, l, pb);
        teclado = 10'h000;
        run(10, l, l, pb);
        checks++; if (s !== 0) begin failures++; $display("FAIL glitch_strobes: got %0d expected 0", s); end
        checks++; if (d !== 4'd9) begin failures++; $display("FAIL glitch_d: got %0d expected 9", d); end
    endtask

    task automatic test_release_reentry();
        int s, l, pb;
        teclado = 10'h010;
        run(10, s, l, pb);
        checks++; if (s !== 1 || d !== 4'd4) begin failures++; $display("FAIL reentry_first: got %0d strobes d=%0d expected 1 d=4", s, d); end
        teclado = 10'h000;
        run(3, s, l, pb);
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL reentry_release_held: got %b expected 1", key_held); end
        teclado = 10'h010;
        run(10, s, l, pb);
        checks++; if (s !== 0) begin failures++; $display("FAIL reentry_3_cycle_gap: got %0d strobes expected 0", s); end
        teclado = 10'h090;
        run(10, s, l, pb);
        checks++; if (s !== 0 || d !== 4'd4) begin failures++; $display("FAIL reentry_other_key: got %0d strobes d=%0d expected 0 d=4", s, d); end
        teclado = 10'h000;
        run(6, s, l, pb);
        teclado = 10'h010;
        run(10, s, l, pb);
        checks++; if (s !== 0) begin failures++; $display("FAIL reentry_6_cycle_gap: got %0d strobes expected 0", s); end
        teclado = 10'h000;
        run(7, s, l, pb);
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reentry_full_release: got %b expected 0", key_held); end
        teclado = 10'h040;
        run(10, s, l, pb);
        checks++; if (s !== 1 || d !== 4'd6) begin failures++; $display("FAIL reentry_new_press: got %0d strobes d=%0d expected 1 d=6", s, d); end
        teclado = 10'h000;
        run(10, s, l, pb);
    endtask

    task automatic test_enable_abort();
        int s1, s2, s3, l, pb;
        teclado = 10'h004;
        run(4, s1, l, pb);
        enablen = 1'b1;
        run(10, s2, l, pb);
        teclado = 10'h000;
        run(2, s3, l, pb);
        enablen = 1'b0;
        run(5, s3, l, pb);
        checks++; if (s1 + s2 + s3 !== 0 || d !== 4'd6) begin failures++; $display("FAIL enable_abort: got %0d strobes d=%0d expected 0 d=6", s1 + s2 + s3, d); end
    endtask

    task automatic test_clear_abort();
        int s, l, pb;
        teclado = 10'h100;
        run(4, s, l, pb);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (d !== 4'd0 || loadn !== 1'b1 || key_strobe !== 1'b0 || key_held !== 1'b0) begin
            failures++; $display("FAIL clear_debounce: got d=%0d loadn=%b strobe=%b held=%b expected 0 1 0 0", d, loadn, key_strobe, key_held);
        end
        run(6, s, l, pb);
        checks++; if (s !== 0) begin failures++; $display("FAIL clear_redebounce_early: got %0d strobes expected 0", s); end
        run(1, s, l, pb);
        checks++; if (s !== 1 || d !== 4'd8) begin failures++; $display("FAIL clear_redebounce: got %0d strobes d=%0d expected 1 d=8", s, d); end
        run(3, s, l, pb);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (key_held !== 1'b0 || d !== 4'd0) begin failures++; $display("FAIL clear_held: got held=%b d=%0d expected 0 0", key_held, d); end
        run(6, s, l, pb);
        checks++; if (s !== 0) begin failures++; $display("FAIL clear_held_early: got %0d strobes expected 0", s); end
        run(1, s, l, pb);
        checks++; if (s !== 1) begin failures++; $display("FAIL clear_held_redebounce: got %0d strobes expected 1", s); end
        teclado = 10'h000;
        run(10, s, l, pb);
    endtask

    task automatic test_divider();
        logic hist [300];
        int r1, r2, f;
        enablen = 1'b1;
        teclado = 10'h000;
        for (int i = 0; i < 300; i++) begin
            step();
            hist[i] = pgt;
        end
        r1 = -1; r2 = -1; f = -1;
        for (int i = 1; i < 300; i++) begin
            if (hist[i-1] == 1'b0 && hist[i] == 1'b1) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            if (r1 >= 0 && f < 0 && hist[i-1] == 1'b1 && hist[i] == 1'b0) f = i;
        end
        checks++; if (r1 < 0 || f < 0 || (f - r1) != 50) begin failures++; $display("FAIL tick_high: got %0d expected 50", f - r1); end
        checks++; if (r2 < 0 || f < 0 || (r2 - f) != 50) begin failures++; $display("FAIL tick_low: got %0d expected 50", r2 - f); end
        checks++; if (r1 < 0 || r2 < 0 || (r2 - r1) != 100) begin failures++; $display("FAIL tick_period: got %0d expected 100", r2 - r1); end
        enablen = 1'b0;
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        int first, n, offs [4];
        first = -1;
        n = 0;
        teclado = 10'h002;
        for (int i = 0; i < 20 && first < 0; i++) begin
            step();
            if (key_strobe === 1'b1) first = i;
        end
        checks++; if (first < 0) begin failures++; $display("FAIL repeat_accept: got none expected strobe"); end
        for (int k = 1; k <= 160; k++) begin
            step();
            if (key_strobe === 1'b1) begin
                if (n < 4) offs[n] = k;
                n++;
            end
        end
        checks++; if (n !== 3) begin failures++; $display("FAIL repeat_count: got %0d expected 3", n); end
        checks++; if (n == 3 && (offs[0] != 50 || offs[1] != 100 || offs[2] != 150)) begin
            failures++; $display("FAIL repeat_offsets: got %0d %0d %0d expected 50 100 150", offs[0], offs[1], offs[2]);
        end
        checks++; if (d !== 4'd1) begin failures++; $display("FAIL repeat_d: got %0d expected 1", d); end
        teclado = 10'h000;
        for (int i = 0; i < 10; i++) step();
    endtask
`endif

    initial begin
        clear   = 1'b1;
        enablen = 1'b0;
        teclado = 10'h000;
        test_reset();
        test_single_press();
        test_priority_glitch();
        test_release_reentry();
        test_enable_abort();
        test_clear_abort();
        test_divider();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
